// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared constants, APB payload type and address helper for the GPIO pad controller.
package gpio_pad_ctrl_pkg;

  localparam int unsigned APB_DW = 32;
  localparam int unsigned APB_AW = 8;

  localparam logic [APB_AW-1:0] ADDR_DOUT     = 8'h00;
  localparam logic [APB_AW-1:0] ADDR_OE       = 8'h04;
  localparam logic [APB_AW-1:0] ADDR_DIN      = 8'h08;
  localparam logic [APB_AW-1:0] ADDR_IRQ_EN   = 8'h0C;
  localparam logic [APB_AW-1:0] ADDR_IRQ_RISE = 8'h10;
  localparam logic [APB_AW-1:0] ADDR_IRQ_FALL = 8'h14;
  localparam logic [APB_AW-1:0] ADDR_IRQ_STAT = 8'h18;

  // One APB request as seen by the slave in a given cycle.
  typedef struct packed {
    logic              sel;
    logic              enable;
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_req_t;

  // Word-align a byte address; the two low bits carry no meaning.
  function automatic logic [APB_AW-1:0] word_addr(input logic [APB_AW-1:0] a);
    return a & 8'hFC;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One-bit input conditioner: two-flop synchroniser, debounce filter and edge detect.
module gpio_debounce
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_y,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          deb_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pad level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pad_y;
      sync <= meta;
    end
  end

  // Accept a new level only after it has differed from deb for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d <= 1'b0;
    end else begin
      deb_d <= deb;
    end
  end

  assign rise = deb & ~deb_d;
  assign fall = ~deb & deb_d;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// APB-programmable GPIO bank: register file, pad drive, input conditioning and interrupt.
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [WIDTH-1:0]  PAD_D,
  output logic [WIDTH-1:0]  PAD_E,
  input  logic [WIDTH-1:0]  PAD_Y,
  output logic              INT
);

  apb_req_t          req;
  logic [APB_AW-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              wr_en;
  logic              unused_bits;

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_rise_q;
  logic [WIDTH-1:0] irq_fall_q;
  logic [WIDTH-1:0] irq_stat_q;

  logic [WIDTH-1:0] deb_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] w1c_vec;

  assign req         = '{sel: PSEL, enable: PENABLE, write: PWRITE, addr: PADDR, wdata: PWDATA};
  assign waddr       = word_addr(req.addr);
  assign wdata       = req.wdata[WIDTH-1:0];
  assign wr_en       = req.sel & req.enable & req.write;
  assign unused_bits = ^{req.wdata, req.addr};

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  // Per-pad synchroniser, debounce and edge detect.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (PCLK),
      .rst_n(PRESETN),
      .pad_y(PAD_Y[i]),
      .deb  (deb_vec[i]),
      .rise (rise_vec[i]),
      .fall (fall_vec[i])
    );
  end

  assign set_vec = (rise_vec & irq_rise_q) | (fall_vec & irq_fall_q);
  assign w1c_vec = (wr_en && (waddr == ADDR_IRQ_STAT)) ? wdata : '0;

  // Register file; a new event in the same cycle beats a write-one-to-clear.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      dout_q     <= '0;
      oe_q       <= '0;
      irq_en_q   <= '0;
      irq_rise_q <= '0;
      irq_fall_q <= '0;
      irq_stat_q <= '0;
    end else begin
      if (wr_en) begin
        case (waddr)
          ADDR_DOUT:     dout_q     <= wdata;
          ADDR_OE:       oe_q       <= wdata;
          ADDR_IRQ_EN:   irq_en_q   <= wdata;
          ADDR_IRQ_RISE: irq_rise_q <= wdata;
          ADDR_IRQ_FALL: irq_fall_q <= wdata;
          default:       ;
        endcase
      end
      irq_stat_q <= (irq_stat_q & ~w1c_vec) | set_vec;
    end
  end

  // Combinational read mux, zero outside a selected transfer.
  always_comb begin
    PRDATA = '0;
    if (req.sel) begin
      case (waddr)
        ADDR_DOUT:     PRDATA = APB_DW'(dout_q);
        ADDR_OE:       PRDATA = APB_DW'(oe_q);
        ADDR_DIN:      PRDATA = APB_DW'(deb_vec);
        ADDR_IRQ_EN:   PRDATA = APB_DW'(irq_en_q);
        ADDR_IRQ_RISE: PRDATA = APB_DW'(irq_rise_q);
        ADDR_IRQ_FALL: PRDATA = APB_DW'(irq_fall_q);
        ADDR_IRQ_STAT: PRDATA = APB_DW'(irq_stat_q);
        default:       PRDATA = '0;
      endcase
    end
  end

  assign PAD_D = dout_q;
  assign PAD_E = oe_q;
  assign INT   = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl (WIDTH=8, DEBOUNCE_CYCLES=16).
module tb_gpio_pad_ctrl;
  import gpio_pad_ctrl_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEB   = 16;

  logic              PCLK = 1'b0;
  logic              PRESETN;
  logic              PSEL, PENABLE, PWRITE;
  logic [7:0]        PADDR;
  logic [31:0]       PWDATA;
  logic [31:0]       PRDATA;
  logic              PREADY, PSLVERR;
  logic [WIDTH-1:0]  PAD_D, PAD_E, PAD_Y;
  logic              INT;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] sb_q[$];

  gpio_pad_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PAD_D(PAD_D), .PAD_E(PAD_E), .PAD_Y(PAD_Y), .INT(INT)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] exp);
    sb_q.push_back(exp);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    if (sb_q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0x%08h", tag, got);
    end else begin
      check_eq(tag, got, sb_q.pop_front());
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    tick(1);
    PENABLE = 1'b1;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    tick(1);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    sb_push(exp);
    apb_read(addr, d);
    sb_check(tag, d);
  endtask

  task automatic expect_sig(input string tag, input logic [31:0] got, input logic [31:0] exp);
    sb_push(exp);
    sb_check(tag, got);
  endtask

  initial begin
    PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PAD_Y = 8'hFF;

    // Reset with pads held high
    tick(3);
    expect_sig("rst_pad_e", 32'(PAD_E), 32'h0);
    expect_sig("rst_pad_d", 32'(PAD_D), 32'h0);
    expect_sig("rst_int", 32'(INT), 32'h0);
    expect_sig("idle_prdata", PRDATA, 32'h0);
    expect_sig("pready", 32'(PREADY), 32'h1);
    expect_sig("pslverr", 32'(PSLVERR), 32'h0);

    PRESETN = 1'b1;
    PSEL = 1'b1; PADDR = ADDR_DIN;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      if (i == 17) expect_sig("din_rst_early", PRDATA, 32'h00);
      if (i == 18) expect_sig("din_rst_lat", PRDATA, 32'hFF);
    end
    PSEL = 1'b0;
    expect_reg("stat_no_rise_en", ADDR_IRQ_STAT, 32'h0);
    PAD_Y = 8'h00;
    tick(20);

    // Output path
    apb_write(ADDR_OE, 32'hA5);
    expect_sig("pad_e", 32'(PAD_E), 32'hA5);
    apb_write(ADDR_DOUT, 32'h3C);
    expect_sig("pad_d", 32'(PAD_D), 32'h3C);
    expect_reg("oe_rd", ADDR_OE, 32'hA5);
    expect_reg("dout_rd", ADDR_DOUT, 32'h3C);
    expect_reg("dout_rd_lowbits", 8'h01, 32'h3C);
    apb_write(ADDR_OE, 32'hFFFF_FF00);
    expect_reg("oe_upper", ADDR_OE, 32'h00);
    expect_sig("pad_e_upper", 32'(PAD_E), 32'h00);
    apb_write(8'h1C, 32'hFFFF_FFFF);
    expect_reg("unmapped_rd", 8'h1C, 32'h0);
    expect_reg("dout_keep", ADDR_DOUT, 32'h3C);

    // 15-cycle glitch is filtered
    apb_write(ADDR_IRQ_RISE, 32'h01);
    PAD_Y = 8'h01;
    tick(15);
    PAD_Y = 8'h00;
    tick(25);
    expect_reg("glitch_din", ADDR_DIN, 32'h0);
    expect_reg("glitch_stat", ADDR_IRQ_STAT, 32'h0);

    // 16-cycle pulse accepted at exactly 18 cycles
    PSEL = 1'b1; PADDR = ADDR_DIN; PAD_Y = 8'h01;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      if (i == 16) PAD_Y = 8'h00;
      if (i == 17) expect_sig("pulse_din_early", PRDATA, 32'h0);
      if (i == 18) expect_sig("pulse_din_lat", PRDATA, 32'h1);
    end
    PSEL = 1'b0;

    // Masked event latches status without interrupt
    expect_reg("mask_stat", ADDR_IRQ_STAT, 32'h1);
    expect_sig("mask_int", 32'(INT), 32'h0);
    tick(25);
    expect_reg("mask_stat_hold", ADDR_IRQ_STAT, 32'h1);
    apb_write(ADDR_IRQ_EN, 32'h01);
    expect_sig("unmask_int", 32'(INT), 32'h1);
    apb_write(ADDR_IRQ_STAT, 32'h01);
    expect_sig("w1c_int", 32'(INT), 32'h0);
    expect_reg("w1c_stat", ADDR_IRQ_STAT, 32'h0);

    // Enabled rising edge, falling edge ignored
    PAD_Y = 8'h01;
    tick(20);
    expect_reg("rise_stat", ADDR_IRQ_STAT, 32'h1);
    expect_sig("rise_int", 32'(INT), 32'h1);
    PAD_Y = 8'h00;
    tick(20);
    expect_reg("fall_no_add", ADDR_IRQ_STAT, 32'h1);
    apb_write(ADDR_IRQ_STAT, 32'h01);
    expect_sig("w1c2_int", 32'(INT), 32'h0);
    expect_reg("w1c2_stat", ADDR_IRQ_STAT, 32'h0);

    // Set beats clear when they collide on bit 2
    apb_write(ADDR_IRQ_FALL, 32'h04);
    apb_write(ADDR_IRQ_EN, 32'h05);
    PAD_Y = 8'h04;
    tick(20);
    PAD_Y = 8'h00;
    tick(20);
    expect_reg("fall2_stat", ADDR_IRQ_STAT, 32'h4);
    PAD_Y = 8'h04;
    tick(20);
    expect_reg("rise2_no_add", ADDR_IRQ_STAT, 32'h4);
    PAD_Y = 8'h00;
    tick(17);
    apb_write(ADDR_IRQ_STAT, 32'h04);
    expect_sig("collide_int", 32'(INT), 32'h1);
    expect_reg("collide_stat", ADDR_IRQ_STAT, 32'h4);
    apb_write(ADDR_IRQ_STAT, 32'h04);
    expect_sig("clear2_int", 32'(INT), 32'h0);
    expect_reg("clear2_stat", ADDR_IRQ_STAT, 32'h0);

    if (sb_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
